// File: rtl/ram_32b_responder_if.sv
// Request/response bundle between a RAM bench (master) and the memory responder (slave).
// state_dbg mirrors the responder's FSM state (0 = clearing, 1 = running).
interface ram_32b_responder_if #(
    parameter int ram_width = 8,
    parameter int add_bits  = 5
);
    logic                 write_sig;
    logic [add_bits-1:0]  write_add;
    logic [ram_width-1:0] ram_input;
    logic                 read_sig;
    logic [add_bits-1:0]  read_add;
    logic [ram_width-1:0] ram_output;
    logic                 read_valid;
    logic                 ready;
    logic [7:0]           drop_cnt;
    logic                 state_dbg;

    modport master (
        output write_sig, write_add, ram_input, read_sig, read_add,
        input  ram_output, read_valid, ready, drop_cnt, state_dbg
    );

    modport slave (
        input  write_sig, write_add, ram_input, read_sig, read_add,
        output ram_output, read_valid, ready, drop_cnt, state_dbg
    );
endinterface

// File: rtl/ram_32b_responder.sv
// Memory-side RAM responder: zero-sweeps the array after reset, then serves one write and
// one read per cycle with a registered, valid-qualified read result.
module ram_32b_responder #(
    parameter int ram_width = 8,
    parameter int add_bits  = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    ram_32b_responder_if.slave   bus
);
    localparam int DEPTH = 2 ** add_bits;
    localparam logic [add_bits-1:0] LAST_ADDR = '1;

    // Handshake: write_sig/read_sig are single-cycle requests taken on an edge only while
    // ready=1; requests seen while ready=0 are dropped and counted. read_valid pulses for
    // exactly the cycle after each accepted read, with ram_output carrying its data.

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t               state;
    state_t               next_state;
    logic [add_bits-1:0]  clr_ptr;
    logic [ram_width-1:0] mem [DEPTH];

    logic                 mem_we;
    logic [add_bits-1:0]  mem_wa;
    logic [ram_width-1:0] mem_wd;
    logic                 rd_accept;
    logic [ram_width-1:0] rd_data;
    logic [8:0]           drop_sum;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        if (state == CLEAR && clr_ptr == LAST_ADDR) next_state = RUN;
    end

    // Output/control logic: the sweep owns the write port until RUN
    always_comb begin
        mem_we    = 1'b0;
        mem_wa    = bus.write_add;
        mem_wd    = bus.ram_input;
        rd_accept = 1'b0;
        case (state)
            CLEAR: begin
                mem_we = rst_n;
                mem_wa = clr_ptr;
                mem_wd = '0;
            end
            RUN: begin
                mem_we    = rst_n & bus.write_sig;
                rd_accept = bus.read_sig;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Write-first bypass when both ports hit the same address on one edge
    always_comb begin
        rd_data = mem[bus.read_add];
        if (bus.write_sig && bus.write_add == bus.read_add) rd_data = bus.ram_input;
    end

    assign drop_sum = {1'b0, bus.drop_cnt} + {8'd0, bus.write_sig} + {8'd0, bus.read_sig};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.ram_output <= '0;
            bus.read_valid <= 1'b0;
            bus.drop_cnt   <= '0;
        end else begin
            bus.read_valid <= rd_accept;
            if (rd_accept) bus.ram_output <= rd_data;
            if (state == CLEAR) bus.drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign bus.ready     = (state == RUN);
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_ram_32b_responder.sv
// Directed bench for ram_32b_responder: behavioural model plus per-cycle compare on the
// default instance, and a wide-address instance used to drive drop_cnt into saturation.
module tb_ram_32b_responder;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ram_32b_responder_if #(.ram_width(8), .add_bits(5)) bus ();
    ram_32b_responder_if #(.ram_width(8), .add_bits(8)) bus2 ();

    ram_32b_responder #(.ram_width(8), .add_bits(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    ram_32b_responder #(.ram_width(8), .add_bits(8)) dut2 (
        .clk  (clk),
        .rst_n(rst2_n),
        .bus  (bus2.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ready after DEPTH released edges, memory all-zero at that point.
    logic [7:0] m_mem [DEPTH];
    int         m_edges;
    logic       m_ready, m_valid, model_live = 1'b0;
    logic [7:0] m_out;
    int         m_drop;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_live = 1'b1;
            m_edges = 0; m_ready = 1'b0; m_valid = 1'b0; m_out = 8'h00; m_drop = 0;
        end else if (m_ready) begin
            m_valid = bus.read_sig;
            if (bus.read_sig)
                m_out = (bus.write_sig && bus.write_add == bus.read_add) ? bus.ram_input
                                                                         : m_mem[bus.read_add];
            if (bus.write_sig) m_mem[bus.write_add] = bus.ram_input;
        end else begin
            m_valid = 1'b0;
            m_drop = m_drop + int'(bus.write_sig) + int'(bus.read_sig);
            if (m_drop > 255) m_drop = 255;
            m_edges++;
            if (m_edges == DEPTH) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("mdl_ready", {31'd0, bus.ready}, {31'd0, m_ready});
            check("mdl_valid", {31'd0, bus.read_valid}, {31'd0, m_valid});
            check("mdl_drop", {24'd0, bus.drop_cnt}, m_drop);
            check("mdl_out", {24'd0, bus.ram_output}, {24'd0, m_out});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write_sig = 1'b0; bus.read_sig = 1'b0;
        bus.write_add = '0;   bus.read_add = '0;  bus.ram_input = '0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        bus.write_sig = 1'b1; bus.write_add = a; bus.ram_input = d;
        step();
        bus.write_sig = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_d;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        idle();
        bus2.write_sig = 1'b0; bus2.read_sig = 1'b0;
        bus2.write_add = '0;   bus2.read_add = '0;  bus2.ram_input = '0;

        // 1. reset for 3 edges, then the sweep
        repeat (3) step();
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_valid", {31'd0, bus.read_valid}, 32'd0);
        check("rst_drop", {24'd0, bus.drop_cnt}, 32'd0);
        check("rst_out", {24'd0, bus.ram_output}, 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            step();
            check("t1_ready_edge", {31'd0, bus.ready}, (k == DEPTH) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            bus.read_sig = 1'b1; bus.read_add = 5'(i);
            step();
            check("t1_zero", {24'd0, bus.ram_output}, 32'd0);
        end
        idle();

        // 2. pattern write then back-to-back readback
        for (int i = 0; i < DEPTH; i++) do_write(5'(i), 8'(i) ^ 8'hA5);
        for (int i = 0; i < DEPTH; i++) begin
            bus.read_sig = 1'b1; bus.read_add = 5'(i);
            step();
            exp_d = 8'(i) ^ 8'hA5;
            check("t2_valid", {31'd0, bus.read_valid}, 32'd1);
            check("t2_data", {24'd0, bus.ram_output}, {24'd0, exp_d});
        end
        idle();
        step();
        check("t2_valid_end", {31'd0, bus.read_valid}, 32'd0);

        // 3. same-edge write/read bypass
        bus.write_sig = 1'b1; bus.write_add = 5'd7; bus.ram_input = 8'h3C;
        bus.read_sig = 1'b1;  bus.read_add = 5'd7;
        step();
        idle();
        check("t3_bypass", {24'd0, bus.ram_output}, 32'h3C);
        check("t3_valid", {31'd0, bus.read_valid}, 32'd1);

        // 5. mid-run reset wipes memory; refused requests during the sweep are counted
        do_write(5'd3, 8'h5A);
        rst_n = 1'b0;
        step();
        check("t5_ready", {31'd0, bus.ready}, 32'd0);
        check("t5_drop", {24'd0, bus.drop_cnt}, 32'd0);
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            bus.write_sig = 1'b1; bus.read_sig = 1'b1; bus.read_add = 5'd3;
            bus.write_add = 5'd3; bus.ram_input = 8'hEE;
            step();
        end
        bus.read_sig = 1'b0;
        for (int j = 0; j < 3; j++) step();
        idle();
        check("t5_drop_cnt", {24'd0, bus.drop_cnt}, 32'd23);
        repeat (DEPTH - 13) step();
        check("t5_ready_back", {31'd0, bus.ready}, 32'd1);
        bus.read_sig = 1'b1; bus.read_add = 5'd3;
        step();
        check("t5_addr3", {24'd0, bus.ram_output}, 32'd0);
        bus.read_add = 5'd5;
        step();
        check("t5_addr5", {24'd0, bus.ram_output}, 32'd0);
        idle();

        // 6. single read then idle cycles hold the data
        do_write(5'd9, 8'h77);
        bus.read_sig = 1'b1; bus.read_add = 5'd9;
        step();
        idle();
        check("t6_valid", {31'd0, bus.read_valid}, 32'd1);
        check("t6_data", {24'd0, bus.ram_output}, 32'h77);
        for (int j = 0; j < 4; j++) begin
            step();
            check("t6_idle_valid", {31'd0, bus.read_valid}, 32'd0);
            check("t6_hold", {24'd0, bus.ram_output}, 32'h77);
        end

        // 4. drop counter saturation on the 256-deep instance
        rst2_n = 1'b1;
        for (int j = 0; j < 200; j++) begin
            bus2.write_sig = 1'b1; bus2.read_sig = 1'b1;
            bus2.write_add = 8'(j); bus2.read_add = 8'(j); bus2.ram_input = 8'hC3;
            step();
            if (j % 50 == 49) check("t4_no_valid", {31'd0, bus2.read_valid}, 32'd0);
        end
        bus2.write_sig = 1'b0; bus2.read_sig = 1'b0;
        check("t4_drop_sat", {24'd0, bus2.drop_cnt}, 32'hFF);
        check("t4_still_clear", {31'd0, bus2.ready}, 32'd0);
        repeat (56) step();
        check("t4_ready", {31'd0, bus2.ready}, 32'd1);
        check("t4_drop_hold", {24'd0, bus2.drop_cnt}, 32'hFF);
        for (int j = 0; j < 4; j++) begin
            bus2.read_sig = 1'b1; bus2.read_add = 8'(j * 60);
            step();
            check("t4_zero", {24'd0, bus2.ram_output}, 32'd0);
            check("t4_valid", {31'd0, bus2.read_valid}, 32'd1);
        end
        bus2.read_sig = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
